// File: rtl/m_cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field layouts.
package m_cp0_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned HWINT_W = 6;

  localparam logic [ADDR_W-1:0] CP0_SR    = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_CAUSE = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_EPC   = 5'd14;
  localparam logic [ADDR_W-1:0] CP0_PRID  = 5'd15;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [XLEN-1:0] EXC_ENTRY = 32'h0000_4180;

  typedef struct packed {
    logic [HWINT_W-1:0] im;
    logic               exl;
    logic               ie;
  } sr_t;

  typedef struct packed {
    logic               bd;
    logic [HWINT_W-1:0] ip;
    logic [EXC_W-1:0]   exc_code;
  } cause_t;

  function automatic logic [XLEN-1:0] pack_sr(input sr_t s);
    return {16'b0, s.im, 8'b0, s.exl, s.ie};
  endfunction

  function automatic logic [XLEN-1:0] pack_cause(input cause_t c);
    return {c.bd, 15'b0, c.ip, 3'b0, c.exc_code, 2'b00};
  endfunction

endpackage

// File: rtl/m_cp0_arb.sv
// Interrupt/exception arbitration: decides Req and the ExcCode to latch.
import m_cp0_pkg::*;

module m_cp0_arb (
  input  logic               reset,
  input  logic               ie,
  input  logic               exl,
  input  logic [HWINT_W-1:0] im,
  input  logic [HWINT_W-1:0] hw_int,
  input  logic [EXC_W-1:0]   exc_code_in,
  output logic               req_c,
  output logic [EXC_W-1:0]   exc_code_nxt_c
);

  logic int_req;
  logic exc_req;

  // Interrupts outrank synchronous exceptions; EXL blocks both.
  always_comb begin
    int_req        = ie & ~exl & (|(hw_int & im));
    exc_req        = ~exl & (exc_code_in != EXC_INT);
    req_c          = ~reset & (int_req | exc_req);
    exc_code_nxt_c = int_req ? EXC_INT : exc_code_in;
  end

endmodule

// File: rtl/m_cp0.sv
// M-stage CP0: SR/Cause/EPC/PRId, exception request and eret restart address.
import m_cp0_pkg::*;

module m_cp0 #(
  parameter logic [XLEN-1:0]    PRID_VALUE  = 32'h2021_0007,
  parameter logic [HWINT_W-1:0] SR_IM_RESET = 6'b000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [ADDR_W-1:0]  CP0Add,
  input  logic [XLEN-1:0]    CP0In,
  input  logic [XLEN-1:0]    VPC,
  input  logic               BDIn,
  input  logic [EXC_W-1:0]   ExcCodeIn,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  output logic [XLEN-1:0]    CP0Out,
  output logic [XLEN-1:0]    EPCOut,
  output logic               Req
);

  sr_t             sr;
  cause_t          cause;
  logic [XLEN-1:0] epc;
  logic [EXC_W-1:0] exc_code_nxt;
  logic [XLEN-1:0] victim_base;
  logic [XLEN-1:0] epc_nxt;
  logic [XLEN-1:0] cp0_in_aligned;
  logic            wr_sr;
  logic            wr_epc;

  m_cp0_arb u_arb (
    .reset          (reset),
    .ie             (sr.ie),
    .exl            (sr.exl),
    .im             (sr.im),
    .hw_int         (HWInt),
    .exc_code_in    (ExcCodeIn),
    .req_c          (Req),
    .exc_code_nxt_c (exc_code_nxt)
  );

  // Delay-slot victims restart at the branch, one word earlier (wraps at 0).
  always_comb begin
    victim_base    = VPC & ~XLEN'(3);
    epc_nxt        = BDIn ? (victim_base - XLEN'(4)) : victim_base;
    cp0_in_aligned = CP0In & ~XLEN'(3);
    wr_sr          = en & ~Req & (CP0Add == CP0_SR);
    wr_epc         = en & ~Req & (CP0Add == CP0_EPC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr.im          <= SR_IM_RESET;
      sr.exl         <= 1'b0;
      sr.ie          <= 1'b0;
      cause.bd       <= 1'b0;
      cause.ip       <= '0;
      cause.exc_code <= '0;
      epc            <= '0;
    end else begin
      cause.ip <= HWInt;
      if (Req) begin
        sr.exl         <= 1'b1;
        cause.bd       <= BDIn;
        cause.exc_code <= exc_code_nxt;
        epc            <= epc_nxt;
      end else begin
        if (wr_sr) begin
          sr.im  <= CP0In[15:10];
          sr.ie  <= CP0In[0];
          // eret in the same cycle overrides the written EXL below.
          sr.exl <= CP0In[1] & ~EXLClr;
        end else if (EXLClr) begin
          sr.exl <= 1'b0;
        end
        if (wr_epc) begin
          epc <= cp0_in_aligned;
        end
      end
    end
  end

  // EPC bypass lets "mtc0 EPC; eret" issue back to back.
  always_comb begin
    EPCOut = (en && (CP0Add == CP0_EPC)) ? cp0_in_aligned : epc;
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      CP0_SR:    CP0Out = pack_sr(sr);
      CP0_CAUSE: CP0Out = pack_cause(cause);
      CP0_EPC:   CP0Out = epc;
      CP0_PRID:  CP0Out = PRID_VALUE;
      default:   CP0Out = '0;
    endcase
  end

endmodule

// File: tb/tb_m_cp0.sv
// Directed plus randomized checks of m_cp0 against a word-level CP0 model.
module tb_m_cp0;

  localparam logic [31:0] PRID = 32'h2021_0007;
  localparam logic [5:0]  IM_RST = 6'b000000;

  logic        clk = 1'b0;
  logic        reset, en, BDIn, EXLClr;
  logic [4:0]  CP0Add, ExcCodeIn;
  logic [31:0] CP0In, VPC;
  logic [5:0]  HWInt;
  logic [31:0] CP0Out, EPCOut;
  logic        Req;

  int checks = 0;
  int errors = 0;

  // Model state kept as whole architectural words / fields.
  logic [31:0] m_sr, m_epc;
  logic        m_bd;
  logic [5:0]  m_ip;
  logic [4:0]  m_code;
  bit          m_valid = 1'b0;

  m_cp0 #(.PRID_VALUE(PRID), .SR_IM_RESET(IM_RST)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
  endfunction

  function automatic logic m_int();
    return m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_req();
    return !reset && (m_int() || (!m_sr[1] && ExcCodeIn != 5'd0));
  endfunction

  function automatic logic [31:0] m_cp0out();
    case (CP0Add)
      5'd12:   return m_sr;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // Compare against the model, then advance model and DUT one clock.
  task automatic step();
    logic        r;
    logic [31:0] n_sr, n_epc;
    logic        n_bd;
    logic [4:0]  n_code;
    #1;
    r = m_req();
    chk("req", 32'(Req), 32'(r));
    if (m_valid) begin
      chk("epcout", EPCOut, (en && CP0Add == 5'd14) ? (CP0In & 32'hFFFF_FFFC) : m_epc);
      chk("cp0out", CP0Out, m_cp0out());
    end
    n_sr = m_sr; n_epc = m_epc; n_bd = m_bd; n_code = m_code;
    if (reset) begin
      n_sr = 32'(IM_RST) << 10; n_epc = 32'd0; n_bd = 1'b0; n_code = 5'd0;
    end else if (r) begin
      n_sr   = m_sr | 32'd2;
      n_bd   = BDIn;
      n_code = m_int() ? 5'd0 : ExcCodeIn;
      n_epc  = (VPC & 32'hFFFF_FFFC) - (BDIn ? 32'd4 : 32'd0);
    end else begin
      if (en && CP0Add == 5'd12) n_sr = CP0In & 32'h0000_FC03;
      if (en && CP0Add == 5'd14) n_epc = CP0In & 32'hFFFF_FFFC;
      if (EXLClr) n_sr = n_sr & ~32'd2;
    end
    @(posedge clk);
    m_ip   = reset ? 6'd0 : HWInt;
    m_sr   = n_sr; m_epc = n_epc; m_bd = n_bd; m_code = n_code;
    m_valid = m_valid | reset;
    #1;
  endtask

  task automatic idle();
    en = 0; CP0Add = 5'd0; CP0In = 0; VPC = 0; BDIn = 0;
    ExcCodeIn = 0; HWInt = 0; EXLClr = 0; reset = 0;
  endtask

  initial begin
    idle();
    // 1: reset and reads
    reset = 1; step();
    reset = 0; CP0Add = 5'd12; #1; chk("rst_sr", CP0Out, 32'd0); step();
    CP0Add = 5'd13; #1; chk("rst_cause", CP0Out, 32'd0); step();
    CP0Add = 5'd14; #1; chk("rst_epc", CP0Out, 32'd0); chk("rst_epcout", EPCOut, 32'd0); step();
    CP0Add = 5'd15; #1; chk("prid", CP0Out, PRID); step();

    // 2: enable IP2, interrupt taken
    en = 1; CP0Add = 5'd12; CP0In = 32'h0000_0401; step();
    en = 0; HWInt = 6'b000001; VPC = 32'h3008; #1; chk("int_req", 32'(Req), 32'd1); step();
    CP0Add = 5'd12; #1; chk("int_sr", CP0Out, 32'h0000_0403); chk("int_req_held", 32'(Req), 32'd0); step();
    CP0Add = 5'd14; #1; chk("int_epc", CP0Out, 32'h3008); step();
    CP0Add = 5'd13; #1; chk("int_cause", CP0Out, 32'h0000_0400); step();

    // 3: overflow in delay slot
    HWInt = 0; en = 1; CP0Add = 5'd12; CP0In = 32'd0; EXLClr = 1; step();
    en = 0; EXLClr = 0; ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h3010;
    #1; chk("exc_req", 32'(Req), 32'd1); step();
    ExcCodeIn = 0; BDIn = 0; CP0Add = 5'd13; #1; chk("exc_cause", CP0Out, 32'h8000_0030); step();
    CP0Add = 5'd14; #1; chk("exc_epc", CP0Out, 32'h300C); step();

    // 4: nested blocked, eret, eret racing a new exception
    ExcCodeIn = 5'd4; #1; chk("nested_req", 32'(Req), 32'd0); step();
    ExcCodeIn = 0; EXLClr = 1; step();
    EXLClr = 0; CP0Add = 5'd12; #1; chk("eret_sr", CP0Out, 32'd0); step();
    ExcCodeIn = 5'd10; EXLClr = 1; step();
    ExcCodeIn = 0; EXLClr = 0; CP0Add = 5'd12; #1; chk("race_sr", CP0Out, 32'd2); step();

    // 5: mtc0 EPC bypass with eret
    en = 1; CP0Add = 5'd14; CP0In = 32'h3043; EXLClr = 1;
    #1; chk("epc_bypass", EPCOut, 32'h3040); step();
    en = 0; EXLClr = 0; #1; chk("epc_written", CP0Out, 32'h3040); step();

    // 6: mtc0 SR dropped under Req; reset mid-handler
    ExcCodeIn = 5'd5; en = 1; CP0Add = 5'd12; CP0In = 32'h0000_FC03; step();
    en = 0; ExcCodeIn = 0; #1; chk("drop_sr", CP0Out, 32'd2); step();
    reset = 1; ExcCodeIn = 5'd5; #1; chk("rst_req", 32'(Req), 32'd0); step();
    reset = 0; ExcCodeIn = 0; CP0Add = 5'd12; #1; chk("rst2_sr", CP0Out, 32'd0); step();

    // EPC wrap-around for a delay-slot fault at address 0
    ExcCodeIn = 5'd4; BDIn = 1; VPC = 32'd0; step();
    ExcCodeIn = 0; BDIn = 0; CP0Add = 5'd14; #1; chk("epc_wrap", CP0Out, 32'hFFFF_FFFC); step();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 99) < 2);
      en        = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: CP0Add = 5'd12;
        1: CP0Add = 5'd13;
        2: CP0Add = 5'd14;
        3: CP0Add = 5'd15;
        default: CP0Add = 5'($urandom);
      endcase
      CP0In     = $urandom;
      VPC       = $urandom;
      BDIn      = 1'($urandom);
      ExcCodeIn = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      EXLClr    = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
